// File: rtl/cpu_clock_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_clock_ctrl_pkg
// Shared definitions for the CPU clock controller: the sequencer state
// encoding that also appears on the State output, and a small helper that
// sizes counters.
// Ports: none (package).
// ----------------------------------------------------------------------------
package cpu_clock_ctrl_pkg;

   localparam int STATE_W = 2;

   // Encoding is visible to software/LEDs through the State port, so the
   // values are fixed explicitly.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   // Bits needed to hold 0..n-1. Never returns 0, so a counter whose
   // terminal count is 1 still gets a legal one-bit vector.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_generator.sv
// ----------------------------------------------------------------------------
// tick_generator
// Free-running prescaler. Counts 0..TICK_COUNT-1 and asserts tick for the
// one cycle in which the count sits at its terminal value, so ticks are
// exactly TICK_COUNT cycles apart and the first one falls TICK_COUNT cycles
// after reset is released.
// Parameters:
//   TICK_COUNT  clock cycles per tick (>= 2)
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high
//   tick   out  one-cycle strobe every TICK_COUNT cycles
// ----------------------------------------------------------------------------
module tick_generator #(
   parameter int TICK_COUNT = 50000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);
   import cpu_clock_ctrl_pkg::*;

   localparam int               CNT_W    = cnt_width(TICK_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);

   logic [CNT_W-1:0] count;

   // NOTE: reset is sampled on the clock edge, so it sits inside the
   // clocked block instead of in the sensitivity list.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
      end else begin
         // NOTE: non-blocking assignment, so every flop sees pre-edge values
         // no matter how the blocks are ordered.
         count <= count + CNT_W'(1);
      end
   end

   assign tick = (count == CNT_LAST);

endmodule

// File: rtl/cpu_clock_controller.sv
// ----------------------------------------------------------------------------
// cpu_clock_controller
// Run / single-step / halt sequencer for the single-cycle CPU. Turns board
// switches and a bouncy push button into a one-cycle CpuClkEn advance pulse.
// Everything runs on Clock; the button is the only asynchronous input.
//
// Build option: define CLKCTRL_BREAKPOINT_EN to build the PC breakpoint
// comparator. Without it Pc/BreakAddr/BreakValid are ignored and BreakHit
// stays 0; the port list is the same in both builds.
//
// Parameters:
//   TICK_COUNT      Clock cycles per prescaler tick (>= 2)
//   DEBOUNCE_TICKS  stable tick samples before the button level changes (>= 1)
//   RUN_DIV         ticks per CpuClkEn pulse in RUN (>= 1)
//   PC_WIDTH        width of Pc / BreakAddr
// Ports:
//   Clock       in   system clock
//   Reset       in   synchronous, active-high; clears every register
//   RunSwitch   in   1 = free-run requested
//   StepButton  in   raw asynchronous push button
//   HaltReq     in   CPU halt request, honoured in RUN only
//   Pc          in   current CPU PC
//   BreakAddr   in   breakpoint address
//   BreakValid  in   breakpoint armed
//   CpuClkEn    out  one-cycle CPU advance pulse
//   State       out  IDLE=0, RUN=1, STEP=2, HALT=3
//   Halted      out  1 while State is HALT
//   BreakHit    out  sticky breakpoint flag
//   CycleCount  out  number of CpuClkEn pulses, wraps modulo 2^32
// ----------------------------------------------------------------------------
module cpu_clock_controller
   import cpu_clock_ctrl_pkg::*;
#(
   parameter int TICK_COUNT     = 50000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int RUN_DIV        = 1,
   parameter int PC_WIDTH       = 32
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                RunSwitch,
   input  logic                StepButton,
   input  logic                HaltReq,
   input  logic [PC_WIDTH-1:0] Pc,
   input  logic [PC_WIDTH-1:0] BreakAddr,
   input  logic                BreakValid,
   output logic                CpuClkEn,
   output logic [STATE_W-1:0]  State,
   output logic                Halted,
   output logic                BreakHit,
   output logic [31:0]         CycleCount
);

   localparam int               DB_W     = cnt_width(DEBOUNCE_TICKS);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_TICKS - 1);
   localparam int               DIV_W    = cnt_width(RUN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   // -------------------------------------------------------------------------
   // Prescaler
   // -------------------------------------------------------------------------
   logic tick;

   tick_generator #(
      .TICK_COUNT (TICK_COUNT)
   ) u_tick_generator (
      .clock (Clock),
      .reset (Reset),
      .tick  (tick)
   );

   // -------------------------------------------------------------------------
   // Button synchroniser
   // -------------------------------------------------------------------------
   logic btn_meta;
   logic btn_sync;

   // NOTE: two flops before any logic looks at the button; the first one may
   // go metastable and gets a full cycle to settle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         btn_meta <= StepButton;
         btn_sync <= btn_meta;
      end
   end

   // -------------------------------------------------------------------------
   // Debouncer: the synchronised button is sampled once per tick. The level
   // only follows it after DEBOUNCE_TICKS consecutive samples that disagree
   // with the current level; any agreeing sample restarts the run.
   // press is a one-cycle event on the debounced rising edge.
   // -------------------------------------------------------------------------
   logic            btn_level;
   logic [DB_W-1:0] db_count;
   logic            press;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         btn_level <= 1'b0;
         db_count  <= '0;
         press     <= 1'b0;
      end else begin
         // NOTE: default first, so press is high for exactly one cycle and
         // no branch is left without an assignment.
         press <= 1'b0;
         if (tick) begin
            if (btn_sync == btn_level) begin
               db_count <= '0;
            end else if (db_count == DB_LAST) begin
               btn_level <= btn_sync;
               db_count  <= '0;
               press     <= btn_sync;
            end else begin
               db_count <= db_count + DB_W'(1);
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Breakpoint comparator
   // -------------------------------------------------------------------------
   logic break_match;

`ifdef CLKCTRL_BREAKPOINT_EN
   assign break_match = BreakValid && (Pc == BreakAddr);
`else
   // No comparator in this build; the inputs are folded into a dummy net so
   // the ports stay identical and nothing dangles.
   logic unused_break_inputs;
   assign unused_break_inputs = ^{BreakValid, Pc, BreakAddr};
   assign break_match         = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Sequencer. All outputs are registered; CpuClkEn rises in the cycle
   // after the tick that completes RUN_DIV ticks, and during the single
   // STEP cycle.
   // -------------------------------------------------------------------------
   state_t           state;
   logic             clk_en;
   logic             halted;
   logic             break_hit;
   logic [DIV_W-1:0] div_count;
   logic             pulse_due;

   assign pulse_due = tick && (div_count == DIV_LAST);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= ST_IDLE;
         clk_en    <= 1'b0;
         halted    <= 1'b0;
         break_hit <= 1'b0;
         div_count <= '0;
      end else begin
         clk_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (RunSwitch) begin
                  state     <= ST_RUN;
                  div_count <= '0;
               end else if (press) begin
                  state  <= ST_STEP;
                  clk_en <= 1'b1;
               end
            end

            // A press arriving here is simply not acted on: it is a
            // one-cycle event, so it cannot be queued for later.
            ST_RUN: begin
               if (HaltReq) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else if (pulse_due && break_match) begin
                  state     <= ST_HALT;
                  halted    <= 1'b1;
                  break_hit <= 1'b1;
               end else if (!RunSwitch) begin
                  state <= ST_IDLE;
               end else if (pulse_due) begin
                  clk_en    <= 1'b1;
                  div_count <= '0;
               end else if (tick) begin
                  div_count <= div_count + DIV_W'(1);
               end
            end

            ST_STEP: begin
               state <= ST_IDLE;
            end

            ST_HALT: begin
               if (press) begin
                  state     <= ST_STEP;
                  clk_en    <= 1'b1;
                  halted    <= 1'b0;
                  break_hit <= 1'b0;
               end else if (!RunSwitch && !HaltReq) begin
                  state     <= ST_IDLE;
                  halted    <= 1'b0;
                  break_hit <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Counts a pulse at the end of the cycle in which CpuClkEn is high.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         CycleCount <= '0;
      end else if (clk_en) begin
         CycleCount <= CycleCount + 32'd1;
      end
   end

   assign CpuClkEn = clk_en;
   assign State    = state;
   assign Halted   = halted;
   // Without the comparator break_hit is never set, so this reads as 0.
   assign BreakHit = break_hit;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// ----------------------------------------------------------------------------
// tb_cpu_clock_controller
// Self-checking bench for cpu_clock_controller with TICK_COUNT=4,
// DEBOUNCE_TICKS=2, RUN_DIV=2. A cycle-level behavioural model (tick by
// modulo arithmetic, debounce by a window of recent samples, run pulses by
// counting ticks since RUN entry) predicts every output; scenario tasks add
// directed checks against hand-derived constants. Compile with
// +define+CLKCTRL_BREAKPOINT_EN to exercise the breakpoint build.
// ----------------------------------------------------------------------------
module tb_cpu_clock_controller;

   localparam int TC = 4;
   localparam int DB = 2;
   localparam int RD = 2;

`ifdef CLKCTRL_BREAKPOINT_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic        Clock;
   logic        Reset;
   logic        RunSwitch;
   logic        StepButton;
   logic        HaltReq;
   logic [31:0] Pc;
   logic [31:0] BreakAddr;
   logic        BreakValid;
   logic        CpuClkEn;
   logic [1:0]  State;
   logic        Halted;
   logic        BreakHit;
   logic [31:0] CycleCount;

   int checks   = 0;
   int failures = 0;

   cpu_clock_controller #(
      .TICK_COUNT     (TC),
      .DEBOUNCE_TICKS (DB),
      .RUN_DIV        (RD),
      .PC_WIDTH       (32)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .RunSwitch  (RunSwitch),
      .StepButton (StepButton),
      .HaltReq    (HaltReq),
      .Pc         (Pc),
      .BreakAddr  (BreakAddr),
      .BreakValid (BreakValid),
      .CpuClkEn   (CpuClkEn),
      .State      (State),
      .Halted     (Halted),
      .BreakHit   (BreakHit),
      .CycleCount (CycleCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------------------------------------------------------- model
   int          m_state   = 0;   // 0 idle, 1 run, 2 step, 3 halt
   bit          m_en      = 1'b0;
   bit          m_brk     = 1'b0;
   logic [31:0] m_count   = '0;
   int          n_edges   = 0;   // edges since the last reset edge
   int          run_ticks = 0;   // ticks seen since entering RUN
   bit          m_meta    = 1'b0;
   bit          m_sync    = 1'b0;
   bit          m_level   = 1'b0;
   bit          m_press   = 1'b0;
   bit          samples[$];

   function automatic void model_edge();
      bit tick, press, due, flip, nen, nbrk;
      int nstate;
      if (Reset) begin
         m_state = 0; m_en = 0; m_brk = 0; m_count = '0;
         n_edges = 0; run_ticks = 0;
         m_meta = 0; m_sync = 0; m_level = 0; m_press = 0;
         samples.delete();
         return;
      end
      n_edges++;
      tick   = (n_edges % TC) == 0;
      press  = m_press;
      nstate = m_state;
      nen    = 1'b0;
      nbrk   = m_brk;
      case (m_state)
         0: begin
            if (RunSwitch) begin nstate = 1; run_ticks = 0; end
            else if (press) begin nstate = 2; nen = 1'b1; end
         end
         1: begin
            due = tick && (((run_ticks + 1) % RD) == 0);
            if (HaltReq) nstate = 3;
            else if (due && BRK_EN && BreakValid && (Pc == BreakAddr)) begin
               nstate = 3; nbrk = 1'b1;
            end else if (!RunSwitch) nstate = 0;
            else begin
               if (tick) run_ticks++;
               nen = due;
            end
         end
         2: nstate = 0;
         default: begin
            if (press) begin nstate = 2; nen = 1'b1; nbrk = 1'b0; end
            else if (!RunSwitch && !HaltReq) begin nstate = 0; nbrk = 1'b0; end
         end
      endcase
      if (m_en) m_count = m_count + 32'd1;
      flip = 1'b0;
      if (tick) begin
         samples.push_back(m_sync);
         if (samples.size() > DB) void'(samples.pop_front());
         if (samples.size() == DB) begin
            flip = 1'b1;
            foreach (samples[i]) if (samples[i] == m_level) flip = 1'b0;
         end
         if (flip) m_level = !m_level;
      end
      m_press = flip && m_level;
      m_sync  = m_meta;
      m_meta  = StepButton;
      m_state = nstate;
      m_en    = nen;
      m_brk   = nbrk;
   endfunction

   function automatic logic [36:0] exp_vec();
      return {2'(m_state), m_en, (m_state == 3), m_brk, m_count};
   endfunction

   function automatic logic [36:0] got_vec();
      return {State, CpuClkEn, Halted, BreakHit, CycleCount};
   endfunction

   // One clock edge; the model sees the same inputs the DUT sampled, and
   // outputs are read 1 time unit after the edge.
   task automatic cycle();
      @(posedge Clock);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      RunSwitch  = 1'b0;
      StepButton = 1'b0;
      HaltReq    = 1'b0;
      BreakValid = 1'b0;
      Pc         = '0;
      BreakAddr  = '0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cycle();
      Reset = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      idle_inputs();
      RunSwitch = 1'b1;
      Reset     = 1'b1;
      repeat (2) cycle();
      if (got_vec() !== 37'd0) begin
         failures++;
         $display("FAIL reset_state got=%h expected=%h", got_vec(), 37'd0);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_model got=%h expected=%h", got_vec(), exp_vec());
      end
      checks++;
      Reset = 1'b0;
   endtask

   task automatic test_run();
      int pulses = 0;
      idle_inputs();
      do_reset();
      RunSwitch = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL run_model edge=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
         if (CpuClkEn === 1'b1) begin
            pulses++;
            if (i != 8 * pulses) begin
               failures++;
               $display("FAIL run_spacing pulse=%0d edge=%0d expected=%0d", pulses, i, 8 * pulses);
            end
            checks++;
            if (CycleCount !== 32'(pulses - 1)) begin
               failures++;
               $display("FAIL run_count got=%0d expected=%0d", CycleCount, pulses - 1);
            end
            checks++;
         end
      end
      if (pulses != 6 || State !== 2'd1 || CycleCount !== 32'd6) begin
         failures++;
         $display("FAIL run_total pulses=%0d state=%0d count=%0d expected 6/1/6", pulses, State, CycleCount);
      end
      checks++;
   endtask

   task automatic test_step_debounce();
      int pulses = 0;
      idle_inputs();
      do_reset();
      // Held for one tick only: a single high sample, must be rejected.
      StepButton = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 4) StepButton = 1'b0;
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL bounce_model cyc=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
         if (CpuClkEn === 1'b1) pulses++;
      end
      if (pulses != 0 || State !== 2'd0) begin
         failures++;
         $display("FAIL bounce_pulse pulses=%0d state=%0d expected 0/0", pulses, State);
      end
      checks++;
      // Held for three ticks: exactly one step.
      StepButton = 1'b1;
      for (int i = 0; i < 28; i++) begin
         if (i == 12) StepButton = 1'b0;
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL step_model cyc=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
         if (CpuClkEn === 1'b1) begin
            pulses++;
            if (State !== 2'd2) begin
               failures++;
               $display("FAIL step_state got=%0d expected=2", State);
            end
            checks++;
         end
      end
      if (pulses != 1 || CycleCount !== 32'd1 || State !== 2'd0) begin
         failures++;
         $display("FAIL step_total pulses=%0d count=%0d state=%0d expected 1/1/0", pulses, CycleCount, State);
      end
      checks++;
   endtask

   task automatic test_halt();
      idle_inputs();
      do_reset();
      RunSwitch = 1'b1;
      repeat (15) cycle();
      HaltReq = 1'b1;               // lands on the edge where pulse 2 is due
      cycle();
      if (State !== 2'd3 || Halted !== 1'b1 || CpuClkEn !== 1'b0 || CycleCount !== 32'd1) begin
         failures++;
         $display("FAIL halt_enter state=%0d halted=%0b en=%0b count=%0d expected 3/1/0/1",
                  State, Halted, CpuClkEn, CycleCount);
      end
      checks++;
      HaltReq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL halt_model cyc=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
      end
      RunSwitch = 1'b0;
      cycle();
      if (State !== 2'd0 || Halted !== 1'b0) begin
         failures++;
         $display("FAIL halt_exit state=%0d halted=%0b expected 0/0", State, Halted);
      end
      checks++;
   endtask

   task automatic test_reset_mid_run();
      int first = -1;
      idle_inputs();
      do_reset();
      RunSwitch = 1'b1;
      repeat ($urandom_range(10, 30)) cycle();
      Reset = 1'b1;
      cycle();
      if (State !== 2'd0 || CpuClkEn !== 1'b0 || CycleCount !== 32'd0 || got_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL midrun_reset got=%h expected=%h", got_vec(), exp_vec());
      end
      checks++;
      Reset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         cycle();
         if (CpuClkEn === 1'b1 && first < 0) first = i;
      end
      if (first != 8) begin
         failures++;
         $display("FAIL midrun_first_pulse edge=%0d expected=8", first);
      end
      checks++;
   endtask

   task automatic test_breakpoint();
      int pulses = 0;
      idle_inputs();
      do_reset();
      RunSwitch  = 1'b1;
      BreakValid = 1'b1;
      Pc         = 32'h0000_000C;
      BreakAddr  = 32'h0000_000C;
      repeat (10) cycle();
      if (State !== (BRK_EN ? 2'd3 : 2'd1) || BreakHit !== BRK_EN ||
          CycleCount !== (BRK_EN ? 32'd0 : 32'd1)) begin
         failures++;
         $display("FAIL brk_hit state=%0d brk=%0b count=%0d expected %0d/%0b/%0d",
                  State, BreakHit, CycleCount, BRK_EN ? 3 : 1, BRK_EN, BRK_EN ? 0 : 1);
      end
      checks++;
      // HaltReq keeps HALT held with the switch off; a press steps once.
      RunSwitch = 1'b0;
      HaltReq   = 1'b1;
      cycle();
      StepButton = 1'b1;
      for (int i = 0; i < 26; i++) begin
         if (i == 12) StepButton = 1'b0;
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL brk_model cyc=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
         if (CpuClkEn === 1'b1) begin
            pulses++;
            if (BreakHit !== 1'b0) begin
               failures++;
               $display("FAIL brk_clear got=%0b expected=0", BreakHit);
            end
            checks++;
         end
      end
      if (pulses != 1 || State !== 2'd0 || CycleCount !== (BRK_EN ? 32'd1 : 32'd2)) begin
         failures++;
         $display("FAIL brk_step pulses=%0d state=%0d count=%0d expected 1/0/%0d",
                  pulses, State, CycleCount, BRK_EN ? 1 : 2);
      end
      checks++;
   endtask

   task automatic test_press_in_run();
      int pulses = 0;
      idle_inputs();
      do_reset();
      RunSwitch = 1'b1;
      for (int i = 1; i <= 44; i++) begin
         if (i == 5)  StepButton = 1'b1;
         if (i == 21) StepButton = 1'b0;
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL press_run_model edge=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
         if (CpuClkEn === 1'b1) begin
            pulses++;
            if (i != 8 * pulses) begin
               failures++;
               $display("FAIL press_run_spacing edge=%0d expected=%0d", i, 8 * pulses);
            end
            checks++;
         end
      end
      if (pulses != 5) begin
         failures++;
         $display("FAIL press_run_total pulses=%0d expected=5", pulses);
      end
      checks++;
   endtask

   task automatic test_random();
      idle_inputs();
      do_reset();
      BreakAddr = 32'h0000_000C;
      for (int i = 0; i < 1500; i++) begin
         Reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) RunSwitch  = ~RunSwitch;
         if ($urandom_range(0, 29) == 0) HaltReq    = ~HaltReq;
         if ($urandom_range(0, 5) == 0)  StepButton = ~StepButton;
         BreakValid = ($urandom_range(0, 3) != 0);
         Pc         = 32'($urandom_range(10, 14));
         cycle();
         if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%h expected=%h", i, got_vec(), exp_vec());
         end
         checks++;
      end
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      idle_inputs();
      test_reset();
      test_run();
      test_step_debounce();
      test_halt();
      test_reset_mid_run();
      test_breakpoint();
      test_press_in_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
